// File: rtl/mod5_tx_if.sv
// Parallel-side handshake and serial output bundle for the mod-5 frame transmitter.
interface mod5_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             start;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             err;

  modport master (
    output din, start,
    input  ready, sout, sout_valid, last, err
  );

  modport slave (
    input  din, start,
    output ready, sout, sout_valid, last, err
  );
endinterface

// File: rtl/mod5_tx.sv
// Serial transmitter: WIDTH data bits MSB-first plus a 3-bit check field making the frame a multiple of 5.
// Optional feature macro: MOD5_TX_SELFCHECK_EN adds an output-side residue tracker driving err.
module mod5_tx #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  mod5_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 3);

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       r_q, r_d;
  logic [1:0]       c_q, c_d;
  logic [2:0]       chk;
  logic             sout_q, sout_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             ready;
  logic             accept;

  function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
    logic [3:0] t;
    t = {r, 1'b0} + {3'b000, b};
    if (t >= 4'd5) t = t - 4'd5;
    return t[2:0];
  endfunction

  // Check value c = (5 - 3*rd mod 5) mod 5; 3 is the weight 8 mod 5 of the shifted data.
  function automatic logic [2:0] check_field(input logic [2:0] rd);
    logic [3:0] p;
    p = {rd, 1'b0} + {1'b0, rd};
    if (p >= 4'd10)     p = p - 4'd10;
    else if (p >= 4'd5) p = p - 4'd5;
    return (p == 4'd0) ? 3'd0 : 3'(4'd5 - p);
  endfunction

  assign ready  = (state_q == IDLE) || (state_q == CHECK && cnt_q == CNT_W'(2));
  assign accept = ready && bus.start;

  // r_q holds the residue of all data bits emitted so far, including the one on sout_q.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    c_d     = c_q;
    chk     = 3'd0;
    sout_d  = 1'b0;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    case (state_q)
      IDLE: ;
      DATA: begin
        vld_d = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          chk     = check_field(r_q);
          c_d     = chk[1:0];
          sout_d  = chk[2];
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          sout_d = sh_q[WIDTH-1];
          sh_d   = sh_q << 1;
          r_d    = mod5_step(r_q, sh_q[WIDTH-1]);
          cnt_d  = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (cnt_q == '0) begin
          sout_d = c_q[1];
          vld_d  = 1'b1;
          cnt_d  = CNT_W'(1);
        end else if (cnt_q == CNT_W'(1)) begin
          sout_d = c_q[0];
          vld_d  = 1'b1;
          last_d = 1'b1;
          cnt_d  = CNT_W'(2);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = DATA;
      sout_d  = bus.din[WIDTH-1];
      vld_d   = 1'b1;
      sh_d    = bus.din << 1;
      r_d     = mod5_step(3'd0, bus.din[WIDTH-1]);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= 3'd0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
    sh_q <= sh_d;
    c_q  <= c_d;
  end

  assign bus.ready      = ready;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = vld_q;
  assign bus.last       = last_q;

`ifdef MOD5_TX_SELFCHECK_EN
  // Tracker watches the registered serial stream only, so it catches faults in the check path too.
  logic [2:0] t_q, t_d, t_next;
  logic       err_q, err_d;

  always_comb begin
    t_next = mod5_step(t_q, sout_q);
    t_d    = t_q;
    err_d  = 1'b0;
    if (last_q) begin
      err_d = (t_next != 3'd0);
      t_d   = 3'd0;
    end else if (vld_q) begin
      t_d = t_next;
    end else if (accept) begin
      t_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q   <= 3'd0;
      err_q <= 1'b0;
    end else begin
      t_q   <= t_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
